// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_DM_BUSY = 2'd2
   } state_t;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - per-access wait counter with sticky timeout flag
module mem_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_busy,
   input  logic i_ready,
   output logic o_timeout,
   output logic o_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   // Abort on the edge that would take the count to TIMEOUT, so mem_en is high exactly TIMEOUT cycles
   assign o_timeout = i_busy && !i_ready && (r_cnt == LAST_WAIT);
   assign o_err     = r_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (!i_busy || i_ready || o_timeout) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (o_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter and sequencer for the shared single-port memory
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   input  logic                i_if_kill,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_valid,
   input  logic                i_dm_req,
   input  logic                i_dm_we,
   input  logic [ADDR_W-1:0]   i_dm_addr,
   input  logic [DATA_W-1:0]   i_dm_wdata,
   input  logic [DATA_W/8-1:0] i_dm_wstrb,
   output logic [DATA_W-1:0]   o_dm_rdata,
   output logic                o_dm_valid,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_wstrb,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   input  logic                i_mem_ready,
   output logic                o_stall_if,
   output logic                o_stall_mem,
   output logic                o_err
);

   localparam int STRB_W = DATA_W / 8;

   state_t              r_state, w_state_nxt;
   logic                r_kill, w_kill_nxt;
   logic                r_mem_en, w_mem_en_nxt;
   logic                r_mem_we, w_mem_we_nxt;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic [STRB_W-1:0]   r_mem_wstrb, w_mem_wstrb_nxt;
   logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
   logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata_nxt;
   logic                r_if_valid, w_if_valid_nxt;
   logic                r_dm_valid, w_dm_valid_nxt;

   logic                w_busy, w_timeout, w_done;
   logic                w_if_pend, w_dm_pend;
   logic [DATA_W-1:0]   w_bus_rdata;

   // A stage keeps its request up during its own valid cycle; that request is already served
   assign w_if_pend   = i_if_req && !r_if_valid;
   assign w_dm_pend   = i_dm_req && !r_dm_valid;
   assign w_busy      = (r_state != ST_IDLE);
   assign w_done      = i_mem_ready || w_timeout;
   assign w_bus_rdata = i_mem_ready ? i_mem_rdata : '0;

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_busy    (w_busy),
      .i_ready   (i_mem_ready),
      .o_timeout (w_timeout),
      .o_err     (o_err)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_kill_nxt      = r_kill;
      w_mem_en_nxt    = r_mem_en;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wstrb_nxt = r_mem_wstrb;
      w_if_rdata_nxt  = r_if_rdata;
      w_dm_rdata_nxt  = r_dm_rdata;
      w_if_valid_nxt  = 1'b0;
      w_dm_valid_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_kill_nxt = 1'b0;
            if (w_dm_pend) begin
               w_state_nxt     = ST_DM_BUSY;
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = i_dm_we;
               w_mem_addr_nxt  = i_dm_addr;
               w_mem_wdata_nxt = i_dm_wdata;
               w_mem_wstrb_nxt = i_dm_we ? i_dm_wstrb : '0;
            end else if (w_if_pend && !i_if_kill) begin
               w_state_nxt     = ST_IF_BUSY;
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = i_if_addr;
               w_mem_wdata_nxt = '0;
               w_mem_wstrb_nxt = '0;
            end
         end
         ST_IF_BUSY: begin
            if (i_if_kill) begin
               w_kill_nxt = 1'b1;
            end
            if (w_done) begin
               w_state_nxt  = ST_IDLE;
               w_kill_nxt   = 1'b0;
               w_mem_en_nxt = 1'b0;
               if (!(r_kill || i_if_kill)) begin
                  w_if_valid_nxt = 1'b1;
                  w_if_rdata_nxt = w_bus_rdata;
               end
            end
         end
         ST_DM_BUSY: begin
            if (w_done) begin
               w_state_nxt     = ST_IDLE;
               w_mem_en_nxt    = 1'b0;
               w_mem_we_nxt    = 1'b0;
               w_mem_wstrb_nxt = '0;
               w_dm_valid_nxt  = 1'b1;
               if (!r_mem_we || w_timeout) begin
                  w_dm_rdata_nxt = w_bus_rdata;
               end
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_mem_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_kill      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_valid  <= 1'b0;
         r_dm_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_kill      <= w_kill_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wstrb <= w_mem_wstrb_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_dm_rdata  <= w_dm_rdata_nxt;
         r_if_valid  <= w_if_valid_nxt;
         r_dm_valid  <= w_dm_valid_nxt;
      end
   end

   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_wstrb = r_mem_wstrb;
   assign o_if_rdata  = r_if_rdata;
   assign o_if_valid  = r_if_valid;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_dm_valid  = r_dm_valid;
   assign o_stall_mem = i_dm_req && !r_dm_valid;
   assign o_stall_if  = (i_if_req && !r_if_valid) || o_stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req, if_kill, dm_req, dm_we, mem_ready;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem, err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
      .o_if_rdata(if_rdata), .o_if_valid(if_valid),
      .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .i_dm_wstrb(dm_wstrb),
      .o_dm_rdata(dm_rdata), .o_dm_valid(dm_valid),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
      .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
      .o_stall_if(stall_if), .o_stall_mem(stall_mem), .o_err(err)
   );

   typedef struct {
      bit          is_dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waits;
      bit          never;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          cfg_waits = 0;
   bit          cfg_never = 1'b0;
   bit          cfg_spurious = 1'b0;
   logic [31:0] q_if[$];
   logic [31:0] q_dm[$];
   logic [31:0] last_if = 32'h0;
   logic [31:0] last_dm = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'h00500093;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers after cfg_waits wait states, data keyed by address
   initial begin
      int rcnt;
      rcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_en) begin
            mem_ready = !cfg_never && (rcnt == cfg_waits);
            mem_rdata = mem_ready ? mem_val(mem_addr) : 32'hDEAD0BAD;
            rcnt++;
         end else begin
            mem_ready = cfg_spurious;
            mem_rdata = 32'h0BADF00D;
            rcnt = 0;
         end
      end
   end

   // Scoreboard: every valid pulse must match the oldest expectation of its stage
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (if_valid) begin
            if (q_if.size() == 0) chk("unexpected_if_valid", 32'd1, 32'd0);
            else begin
               e = q_if.pop_front();
               chk("if_rdata", if_rdata, e);
            end
         end
         if (dm_valid) begin
            if (q_dm.size() == 0) chk("unexpected_dm_valid", 32'd1, 32'd0);
            else begin
               e = q_dm.pop_front();
               chk("dm_rdata", dm_rdata, e);
            end
         end
      end
   end

   task automatic run_txn(input vec_t v);
      logic [31:0] exp_rd;
      logic [3:0]  exp_strb;
      int          t0, lat, en_cnt;
      bit          got, stall_ok, stable;
      exp_rd   = v.never ? 32'h0 : ((v.is_dm && v.we) ? last_dm : mem_val(v.addr));
      exp_strb = (v.is_dm && v.we) ? v.wstrb : 4'h0;
      cfg_waits = v.waits;
      cfg_never = v.never;
      tick;
      if (v.is_dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.wstrb;
         q_dm.push_back(exp_rd);
         last_dm = exp_rd;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
         q_if.push_back(exp_rd);
         last_if = exp_rd;
      end
      t0 = cyc; lat = 0; en_cnt = 0; got = 1'b0; stall_ok = 1'b1; stable = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (v.is_dm ? dm_valid : if_valid) begin
            got = 1'b1;
            lat = cyc - t0;
            if (stall_if !== 1'b0 || stall_mem !== 1'b0) stall_ok = 1'b0;
         end else begin
            if (stall_if !== 1'b1 || stall_mem !== v.is_dm) stall_ok = 1'b0;
            if (mem_en) begin
               if (en_cnt == 0) begin
                  chk("mem_addr", mem_addr, v.addr);
                  chk("mem_we", {31'd0, mem_we}, {31'd0, v.is_dm && v.we});
                  chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
                  if (v.is_dm && v.we) chk("mem_wdata", mem_wdata, v.wdata);
               end else if (mem_addr !== v.addr || mem_wstrb !== exp_strb) begin
                  stable = 1'b0;
               end
               en_cnt++;
            end
         end
      end
      if (!got) begin
         chk("valid_wait_expired", 32'd0, 32'd1);
      end else begin
         chk("latency", lat, v.never ? TO + 1 : v.waits + 2);
         chk("mem_en_cycles", en_cnt, v.never ? TO : v.waits + 1);
         chk("stall_during_txn", {31'd0, stall_ok}, 32'd1);
         chk("bus_stable", {31'd0, stable}, 32'd1);
      end
      tick;
      dm_req = 1'b0;
      if_req = 1'b0;
   endtask

   initial begin
      vec_t vecs[7];
      bit   seen_if, seen_dm, stall_if_ok, stall_mem_ok, prev_en, stale;
      int   ngrant;

      if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'h0;

      vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3, 3, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'h0, 2, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h2008, 32'h0,        4'h0, 0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h200C, 32'h12345678, 4'hF, 0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h108,  32'h0,        4'h0, TO - 1, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // Collision: load wins, fetch follows
      cfg_waits = 0; cfg_never = 1'b0;
      tick;
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
      q_dm.push_back(mem_val(32'h2000)); last_dm = mem_val(32'h2000);
      q_if.push_back(mem_val(32'h300));  last_if = mem_val(32'h300);
      seen_if = 1'b0; seen_dm = 1'b0; stall_if_ok = 1'b1; stall_mem_ok = 1'b1; prev_en = 1'b0; ngrant = 0;
      for (int i = 0; i < 20 && !seen_if; i++) begin
         @(negedge clk);
         if (mem_en && !prev_en) begin
            ngrant++;
            if (ngrant == 1) chk("coll_first_addr", mem_addr, 32'h2000);
            else chk("coll_second_addr", mem_addr, 32'h300);
         end
         prev_en = mem_en;
         if (if_valid) seen_if = 1'b1;
         else if (stall_if !== 1'b1) stall_if_ok = 1'b0;
         if (dm_valid) begin
            seen_dm = 1'b1;
            if (stall_mem !== 1'b0) stall_mem_ok = 1'b0;
         end else if (!seen_dm && stall_mem !== 1'b1) stall_mem_ok = 1'b0;
         @(posedge clk); #1;
         if (seen_dm) dm_req = 1'b0;
      end
      if_req = 1'b0;
      chk("coll_both_done", {30'd0, seen_dm, seen_if}, 32'd3);
      chk("coll_grants", ngrant, 2);
      chk("coll_stall_if", {31'd0, stall_if_ok}, 32'd1);
      chk("coll_stall_mem", {31'd0, stall_mem_ok}, 32'd1);

      // Flush during an in-flight fetch
      cfg_waits = 2;
      tick; if_req = 1'b1; if_addr = 32'h400;
      tick;
      tick; if_kill = 1'b1; if_req = 1'b0;
      tick; if_kill = 1'b0;
      @(negedge clk);
      chk("kill_bus_completes", {31'd0, mem_en}, 32'd1);
      repeat (3) tick;
      chk("kill_if_rdata_kept", if_rdata, last_if);
      chk("kill_bus_idle", {31'd0, mem_en}, 32'd0);
      run_txn('{1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 1, 1'b0});

      // Ready while idle is ignored
      cfg_spurious = 1'b1;
      repeat (4) tick;
      cfg_spurious = 1'b0;
      chk("spurious_no_access", {31'd0, mem_en}, 32'd0);

      // Watchdog
      chk("err_before_timeout", {31'd0, err}, 32'd0);
      run_txn('{1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 0, 1'b1});
      chk("err_after_timeout", {31'd0, err}, 32'd1);
      chk("timeout_bus_idle", {31'd0, mem_en}, 32'd0);
      run_txn('{1'b0, 1'b0, 32'h10C, 32'h0, 4'h0, 1, 1'b0});
      chk("err_sticky", {31'd0, err}, 32'd1);

      // Asynchronous reset in the middle of a store
      cfg_waits = 5;
      tick;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h600; dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'hF;
      tick; tick;
      @(negedge clk);
      chk("rst_mid_pre_en", {31'd0, mem_en}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mid_err", {31'd0, err}, 32'd0);
      chk("rst_mid_valids", {30'd0, if_valid, dm_valid}, 32'd0);
      dm_req = 1'b0;
      last_dm = 32'h0; last_if = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (dm_valid || mem_en) stale = 1'b1;
      end
      chk("rst_no_stale_access", {31'd0, stale}, 32'd0);
      chk("rst_dm_rdata_cleared", dm_rdata, 32'h0);
      chk("scoreboard_drained", q_if.size() + q_dm.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish, errors=%0d", errors);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-port unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store). One request is granted at a time. The block drives the memory handshake, returns read data to the owning stage, and generates stall requests that the pipeline control merges with the load-use stall (PCWrite/IFIDWrite low, bubble insert). The MEM stage has priority because it holds the older instruction. A watchdog flags a memory that never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes = DATA_W/8)
- TIMEOUT, 255, max cycles a granted access may wait for mem_ready before abort
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_kill  in  1  branch/jump flush: discard pending/in-flight fetch
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_en  out  1  memory access active
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  DATA_W/8  byte enables (0 on reads)
- mem_rdata  in  DATA_W  read data, valid when mem_ready
- mem_ready  in  1  access complete this cycle
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze the whole pipeline
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE: if dm_req, latch the data request and go to DM_BUSY. Else, if if_req && !if_kill, latch the fetch and go to IF_BUSY. Else stay.
- BUSY states: mem_* driven from the latched request, held stable. The access completes on the first cycle with mem_ready=1. mem_rdata is registered into if_rdata/dm_rdata, and the state returns to IDLE.
- No preemption. A dm_req arriving during IF_BUSY waits until the fetch completes, then wins the next IDLE arbitration even if if_req is also high.
- if_kill during IF_BUSY sets a kill flag. The access still completes on the bus, but if_valid is suppressed and if_rdata is unchanged. The flag clears on return to IDLE.
- if_kill in IDLE blocks a fetch start that cycle.
- Stores: dm_valid pulses on completion; dm_rdata holds its previous value.
- stall_mem = dm_req && !dm_valid.
- stall_if = (if_req && !if_valid) || stall_mem.
- Watchdog: a cycle counter (width clog2(TIMEOUT+1)) clears on entry to a BUSY state and increments each BUSY cycle without mem_ready. When it reaches TIMEOUT: set err, drop mem_en, pulse the owner's valid with rdata = 0, go to IDLE. err stays set until reset.

## Timing
- Reset values (asynchronous): state IDLE; mem_en, mem_we, if_valid, dm_valid, err = 0; mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata = 0; kill flag and counter = 0.
- Asserting rst_n mid-access aborts the access immediately: mem_en falls without waiting for a clock edge, and no valid pulse is produced.
- Request sampled in IDLE at edge T → mem_en high from T+1.
- mem_ready at cycle T+k → valid pulse at T+k+1, FSM in IDLE at T+k+1.
- Minimum latency is 2 cycles (zero-wait memory). Back-to-back accesses therefore complete every 2 cycles.
- mem_* outputs and valid pulses are registered. stall_if/stall_mem are combinational from the inputs and the valid registers.
- Simultaneous dm_req and if_req in IDLE → data granted. The fetch starts in the IDLE cycle after dm_valid.
- mem_ready while not BUSY is ignored.

## Structure
- Shared package (pipeline pkg): state encoding constants (IDLE=2'd0, IF_BUSY=2'd1, DM_BUSY=2'd2) and default TIMEOUT.
- One natural sub-module: mem_watchdog (counter, compare, sticky err). Arbitration and the FSM stay in the top module.

## Test plan
- Zero-wait fetch: if_req, addr 0x100, mem_ready the cycle after grant, rdata 0x00500093 → if_valid 2 cycles after request with if_rdata = 0x00500093; stall_if low on the valid cycle.
- Collision: if_req and dm_req (load 0x2000) in the same cycle → load served first (mem_addr 0x2000), then fetch; stall_if high throughout; stall_mem drops at dm_valid.
- Store, 3 wait states: dm_we=1, wstrb 4'b0011, wdata 0xDEADBEEF → mem_wstrb = 0011 for 4 cycles; dm_valid 1 cycle after mem_ready; dm_rdata unchanged.
- Flush: if_kill one cycle after fetch grant → bus access completes, no if_valid, if_rdata unchanged; next fetch proceeds normally.
- Timeout: TIMEOUT=8, mem_ready never asserted → mem_en high for 8 cycles, err = 1, owner's valid pulses with rdata 0, FSM in IDLE.
- Reset mid-access: rst_n low during DM_BUSY → mem_en, err and valids low immediately; after release, no stale dm_valid.
